fifo_lvl: RTL

//   Synchronous single-clock FIFO with show-ahead read, fill-level output,

---
 rtl/fifo_lvl_pkg.sv | 23 ++
 rtl/fifo_lvl_ram.sv | 25 ++
 rtl/fifo_lvl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fifo_lvl_pkg.sv
// Shared helpers for the fifo_lvl slice: depth arithmetic, threshold range checks
// and the per-cycle access decision record.
package fifo_lvl_pkg;

   // Accepted (not merely requested) accesses for one clock edge.
   typedef struct packed {
      logic wr;
      logic rd;
   } acc_t;

   function automatic int fifo_depth(input int addrw);
      return 1 << addrw;
   endfunction

   function automatic bit afull_thr_ok(input int thr, input int addrw);
      return (thr >= 1) && (thr <= fifo_depth(addrw));
   endfunction

   function automatic bit aempty_thr_ok(input int thr, input int addrw);
      return (thr >= 0) && (thr <= fifo_depth(addrw) - 1);
   endfunction

endpackage

// File: rtl/fifo_lvl_ram.sv
// DEPTH x DATAW storage: one synchronous write port, one asynchronous read port
// so the FIFO head is visible in the same cycle it becomes valid.
module fifo_lvl_ram #(
   parameter int DATAW = 8,
   parameter int ADDRW = 2
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ADDRW-1:0] waddr,
   input  logic [DATAW-1:0] wdata,
   input  logic [ADDRW-1:0] raddr,
   output logic [DATAW-1:0] rdata
);

   logic [DATAW-1:0] mem [2**ADDRW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_lvl.sv
// Show-ahead single-clock FIFO with fill level, almost-full/empty thresholds and
// sticky error flags. Define FIFO_LVL_WATERMARK_EN to add the high-watermark register.
module fifo_lvl
   import fifo_lvl_pkg::*;
#(
   parameter int DATAW      = 8,
   parameter int ADDRW      = 2,
   parameter int AFULL_THR  = (2**ADDRW)-1,
   parameter int AEMPTY_THR = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [DATAW-1:0] i_wr_data,
   output logic             o_wr_full,
   output logic             o_wr_afull,
   input  logic             i_rd_en,
   output logic [DATAW-1:0] o_rd_data,
   output logic             o_rd_empty,
   output logic             o_rd_aempty,
   output logic [ADDRW:0]   o_level,
   output logic             o_ovf,
   output logic             o_udf,
   input  logic             i_clr_err,
   output logic [ADDRW:0]   o_peak
);

   localparam int             DEPTH    = fifo_depth(ADDRW);
   localparam logic [ADDRW:0] DEPTH_L  = (ADDRW+1)'(DEPTH);
   localparam logic [ADDRW:0] AFULL_L  = (ADDRW+1)'(AFULL_THR);
   localparam logic [ADDRW:0] AEMPTY_L = (ADDRW+1)'(AEMPTY_THR);
   localparam logic [ADDRW:0] PTR_ONE  = (ADDRW+1)'(1);

   generate
      if (!afull_thr_ok(AFULL_THR, ADDRW)) begin : g_bad_afull
         $error("fifo_lvl: AFULL_THR=%0d outside 1..%0d", AFULL_THR, DEPTH);
      end
      if (!aempty_thr_ok(AEMPTY_THR, ADDRW)) begin : g_bad_aempty
         $error("fifo_lvl: AEMPTY_THR=%0d outside 0..%0d", AEMPTY_THR, DEPTH-1);
      end
   endgenerate

   logic [ADDRW:0] wr_ptr_reg, wr_ptr_next;
   logic [ADDRW:0] rd_ptr_reg, rd_ptr_next;
   logic           ovf_reg, udf_reg;
   acc_t           acc;

   // Extra pointer bit distinguishes full from empty; level is the modular difference.
   assign o_level     = wr_ptr_reg - rd_ptr_reg;
   assign o_wr_full   = (o_level == DEPTH_L);
   assign o_rd_empty  = (o_level == '0);
   assign o_wr_afull  = (o_level >= AFULL_L);
   assign o_rd_aempty = (o_level <= AEMPTY_L);
   assign o_ovf       = ovf_reg;
   assign o_udf       = udf_reg;

   always_comb begin
      acc         = '0;
      acc.wr      = i_wr_en && !o_wr_full;
      acc.rd      = i_rd_en && !o_rd_empty;
      wr_ptr_next = acc.wr ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;
      rd_ptr_next = acc.rd ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // Error set beats a same-cycle clear so no event is ever lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_reg <= 1'b0;
         udf_reg <= 1'b0;
      end else begin
         if (i_wr_en && o_wr_full) begin
            ovf_reg <= 1'b1;
         end else if (i_clr_err) begin
            ovf_reg <= 1'b0;
         end
         if (i_rd_en && o_rd_empty) begin
            udf_reg <= 1'b1;
         end else if (i_clr_err) begin
            udf_reg <= 1'b0;
         end
      end
   end

`ifdef FIFO_LVL_WATERMARK_EN
   logic [ADDRW:0] peak_reg;

   // Clear reloads the current level rather than zero, so a clear never under-reports.
   always_ff @(posedge clk) begin
      if (rst) begin
         peak_reg <= '0;
      end else if (i_clr_err) begin
         peak_reg <= o_level;
      end else if (o_level > peak_reg) begin
         peak_reg <= o_level;
      end
   end

   assign o_peak = peak_reg;
`else
   assign o_peak = '0;
`endif

   fifo_lvl_ram #(
      .DATAW (DATAW),
      .ADDRW (ADDRW)
   ) u_ram (
      .clk   (clk),
      .we    (acc.wr),
      .waddr (wr_ptr_reg[ADDRW-1:0]),
      .wdata (i_wr_data),
      .raddr (rd_ptr_reg[ADDRW-1:0]),
      .rdata (o_rd_data)
   );

endmodule
